systolic_out_collector: RTL



---
 rtl/systolic_out_collector_if.sv | 26 ++
 rtl/systolic_out_collector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/systolic_out_collector_if.sv
// Row-write channel from the output collector to the output feature-map buffer.
// master drives wr_valid/wr_addr/wr_data and samples wr_ready; slave is the buffer side.
interface systolic_out_collector_if #(
    parameter int width  = 16,
    parameter int col    = 32,
    parameter int addr_w = 10
);
    logic              wr_valid;
    logic              wr_ready;
    logic [addr_w-1:0] wr_addr;
    logic [width-1:0]  wr_data [col];

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/systolic_out_collector.sv
// Output collector: per-column FIFOs re-align the column-skewed array results
// into full rows and write them to the output buffer at auto-incrementing addresses.
//   clk, nrst           : clock, synchronous active-low reset
//   start               : arms a run, samples num_filter (active cols - 1) and base_addr
//   out_en/systolic_out : per-column result valid and data
//   conv_finish         : array has issued its last result
//   wr (master)         : wr_valid/wr_ready/wr_addr/wr_data row writes
//   overflow, row_err   : sticky error flags; collect_done: one-cycle completion pulse
module systolic_out_collector #(
    parameter int width  = 16,
    parameter int col    = 32,
    parameter int depth  = 32,
    parameter int addr_w = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [4:0]        num_filter,
    input  logic [addr_w-1:0] base_addr,
    input  logic              out_en [col],
    input  logic [width-1:0]  systolic_out [col],
    input  logic              conv_finish,
    systolic_out_collector_if.master wr,
    output logic              overflow,
    output logic              row_err,
    output logic              collect_done
);
    localparam int pw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]                state;
    logic [4:0]                nf_q;
    logic [addr_w-1:0]         addr_q;
    logic [col-1:0][cw-1:0]    cnt;
    logic [col-1:0][pw-1:0]    rd_ptr;
    logic [col-1:0][pw-1:0]    wr_ptr;
    logic [col-1:0][width-1:0] head;
    logic [col-1:0]            active;
    logic [col-1:0]            nonempty;
    logic [col-1:0]            accept;
    logic [col-1:0]            drop;
    logic                      run;
    logic                      row_ok;
    logic                      pop;
    logic                      any_left;
    logic                      flush;

    function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
        return (p == pw'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < col; g++) begin : g_col
        logic [width-1:0] mem [depth];

        always_ff @(posedge clk) begin
            if (accept[g]) begin
                mem[wr_ptr[g]] <= systolic_out[g];
            end
        end

        assign head[g] = mem[rd_ptr[g]];
    end

    always_comb begin
        run      = (state == COLLECT) || (state == DRAIN);
        active   = '0;
        nonempty = '0;
        for (int c = 0; c < col; c++) begin
            active[c]   = (c <= int'(nf_q));
            nonempty[c] = (cnt[c] != '0);
        end
        row_ok   = run && ((active & ~nonempty) == '0);
        pop      = row_ok && wr.wr_ready;
        any_left = |(active & nonempty);
        // DRAIN ends as soon as no full row is left; leftovers are discarded
        flush    = ((state == IDLE) && start) ||
                   ((state == DRAIN) && !row_ok);
        accept   = '0;
        drop     = '0;
        for (int c = 0; c < col; c++) begin
            // a pop frees a slot in every active FIFO in the same cycle
            accept[c] = run && active[c] && out_en[c] &&
                        ((cnt[c] != cw'(depth)) || pop);
            drop[c]   = run && active[c] && out_en[c] && !accept[c];
        end
    end

    always_comb begin
        for (int c = 0; c < col; c++) begin
            wr.wr_data[c] = (row_ok && active[c]) ? head[c] : '0;
        end
    end

    assign wr.wr_valid   = row_ok;
    assign wr.wr_addr    = addr_q;
    assign collect_done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            nf_q     <= '0;
            addr_q   <= '0;
            overflow <= 1'b0;
            row_err  <= 1'b0;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nf_q     <= num_filter;
                        addr_q   <= base_addr;
                        overflow <= 1'b0;
                        row_err  <= 1'b0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (conv_finish) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!row_ok) begin
                        state <= DONE;
                        if (any_left) begin
                            row_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (pop) begin
                addr_q <= addr_q + 1'b1;
            end
            if (|drop) begin
                overflow <= 1'b1;
            end

            if (flush) begin
                cnt    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                for (int c = 0; c < col; c++) begin
                    if (accept[c]) begin
                        wr_ptr[c] <= nxt(wr_ptr[c]);
                    end
                    if (pop && active[c]) begin
                        rd_ptr[c] <= nxt(rd_ptr[c]);
                    end
                    cnt[c] <= cnt[c] + cw'(accept[c]) - cw'(pop && active[c]);
                end
            end
        end
    end
endmodule
